// File: rtl/ifmap_diag_sender_pkg.sv
// Shared constants and types for the diagonal ifmap sender and its per-lane transmitters.
package ifmap_diag_sender_pkg;

    localparam int NUM_ROW   = 6;
    localparam int NUM_COL   = 7;
    localparam int NUM_DIAG  = NUM_ROW + NUM_COL - 1;
    localparam int BEAT_W    = 10;
    localparam int PAYLOAD_W = 16;
    localparam int STALL_W   = 16;

    typedef struct packed {
        logic                 valid;
        logic [PAYLOAD_W-1:0] data;
    } PE_IN_PACKET;

    typedef PE_IN_PACKET [0:NUM_DIAG-1] DIAGONAL_BUS_PACKET;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } SENDER_STATE;

endpackage

// File: rtl/ifmap_diag_sender_lane_tx.sv
// One diagonal lane: staging register, post-send hold-off, beat counter, bus register.
// Optional stall counter is built when IFMAP_STALL_CNT_EN is defined.
module ifmap_lane_tx
    import ifmap_diag_sender_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 stream_i,
    input  logic                 en_i,
    input  logic [BEAT_W-1:0]    bpp_i,
    input  logic                 blocked_i,
    input  logic                 src_valid_i,
    input  logic [PAYLOAD_W-1:0] src_data_i,
    output logic                 src_ready_o,
    output PE_IN_PACKET          bus_o,
    output logic                 done_o
`ifdef IFMAP_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0]   stall_cnt_o
`endif
);

    logic                 stg_v_q, stg_v_d;
    logic [PAYLOAD_W-1:0] stg_d_q, stg_d_d;
    logic                 hold_q;
    logic [BEAT_W-1:0]    cnt_q, cnt_d;
    logic [BEAT_W:0]      cnt_inc;
    PE_IN_PACKET          bus_q, bus_d;
    logic                 send;
    logic                 room;
    logic                 accept;

    assign send    = stg_v_q & ~blocked_i & ~hold_q;
    assign cnt_inc = {1'b0, cnt_q} + {{BEAT_W{1'b0}}, 1'b1};

    // A staged beat is already committed, so it counts against the pass budget;
    // without this the lane would accept one beat more than beats_per_pass.
    assign room        = stg_v_q ? (send & (cnt_inc < {1'b0, bpp_i})) : (cnt_q < bpp_i);
    assign src_ready_o = stream_i & en_i & room;
    assign accept      = src_ready_o & src_valid_i;
    assign done_o      = ~en_i | (cnt_q == bpp_i);
    assign bus_o       = bus_q;

    always_comb begin
        stg_v_d = stg_v_q;
        stg_d_d = stg_d_q;
        cnt_d   = cnt_q;
        bus_d   = '0;
        if (clr_i) begin
            stg_v_d = 1'b0;
            cnt_d   = '0;
        end else begin
            if (send) begin
                stg_v_d    = 1'b0;
                bus_d.valid = 1'b1;
                bus_d.data  = stg_d_q;
                if (cnt_q != bpp_i) cnt_d = cnt_q + BEAT_W'(1);
            end
            if (accept) begin
                stg_v_d = 1'b1;
                stg_d_d = src_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg_v_q <= 1'b0;
            stg_d_q <= '0;
            hold_q  <= 1'b0;
            cnt_q   <= '0;
            bus_q   <= '0;
        end else begin
            stg_v_q <= stg_v_d;
            stg_d_q <= stg_d_d;
            hold_q  <= send;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
        end
    end

`ifdef IFMAP_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (clr_i) begin
            stall_d = '0;
        end else if (stream_i & en_i & stg_v_q & blocked_i & (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_q <= '0;
        else      stall_q <= stall_d;
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: rtl/ifmap_diag_sender.sv
// Diagonal ifmap broadcast sender: pass FSM plus per-diagonal pe_full reduction.
// Define IFMAP_STALL_CNT_EN to add the per-lane stall_cnt output.
//
// state  | meaning
// IDLE   | waiting for start; lane config latched on start
// STREAM | enabled lanes stream beats until each reaches beats_per_pass
// DONE   | pass finished; waiting for conv_continue
module ifmap_diag_sender
    import ifmap_diag_sender_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                conv_continue,
    input  logic [NUM_DIAG-1:0]                 lane_en,
    input  logic [BEAT_W-1:0]                   beats_per_pass,
    input  logic [NUM_DIAG-1:0]                 src_valid,
    input  logic [NUM_DIAG-1:0][PAYLOAD_W-1:0]  src_data,
    output logic [NUM_DIAG-1:0]                 src_ready,
    input  logic [NUM_ROW-1:0][NUM_COL-1:0]     pe_full,
    output DIAGONAL_BUS_PACKET                  diagonal_bus_packet,
    output logic                                busy,
    output logic                                pass_done,
    output logic                                error
`ifdef IFMAP_STALL_CNT_EN
    ,
    output logic [NUM_DIAG-1:0][STALL_W-1:0]    stall_cnt
`endif
);

    SENDER_STATE         state_q, state_d;
    logic [NUM_DIAG-1:0] en_q;
    logic [BEAT_W-1:0]   bpp_q;
    logic                pass_done_q, pass_done_d;
    logic                error_q, error_d;
    logic                clr;
    logic [NUM_DIAG-1:0] blocked;
    logic [NUM_DIAG-1:0] lane_done;

    always_comb begin
        blocked = '0;
        for (int i = 0; i < NUM_ROW; i++) begin
            for (int j = 0; j < NUM_COL; j++) begin
                blocked[i+j] = blocked[i+j] | pe_full[i][j];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    state_d = ((beats_per_pass == '0) || (lane_en == '0)) ? DONE : STREAM;
                end
            end
            STREAM:  if (&lane_done) state_d = DONE;
            DONE:    if (conv_continue) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        pass_done_d = (state_d == DONE) && (state_q != DONE);
        error_d     = error_q | (start & (state_q != IDLE));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            en_q        <= '0;
            bpp_q       <= '0;
            pass_done_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pass_done_q <= pass_done_d;
            error_q     <= error_d;
            if (clr) begin
                en_q  <= lane_en;
                bpp_q <= beats_per_pass;
            end
        end
    end

    assign busy      = (state_q == STREAM);
    assign pass_done = pass_done_q;
    assign error     = error_q;

    for (genvar d = 0; d < NUM_DIAG; d++) begin : g_lane
        ifmap_lane_tx u_lane (
            .clk         (clk),
            .rst         (rst),
            .clr_i       (clr),
            .stream_i    (busy),
            .en_i        (en_q[d]),
            .bpp_i       (bpp_q),
            .blocked_i   (blocked[d]),
            .src_valid_i (src_valid[d]),
            .src_data_i  (src_data[d]),
            .src_ready_o (src_ready[d]),
            .bus_o       (diagonal_bus_packet[d]),
            .done_o      (lane_done[d])
`ifdef IFMAP_STALL_CNT_EN
            ,
            .stall_cnt_o (stall_cnt[d])
`endif
        );
    end

endmodule
